// File: rtl/mc_controller_hs.sv
// Multicycle MIPS-style controller with memory wait-state handshake, timeout trap and
// illegal-instruction trap. Optional retired-instruction counter under MC_CTRL_PERF_EN.
module mc_controller_hs #(
  parameter int FUNC_W      = 9,
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int PERF_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         opc,
  input  logic [FUNC_W-1:0]  func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [1:0]         PCSrc,
  output logic               PCWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               Reg1Src,
  output logic               RegDst,
  output logic [1:0]         writeSrc,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               trap,
  output logic [1:0]         trap_cause
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]  instr_retired
`endif
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [4:0] {
    S_IF, S_ID, S_LD1, S_LD2, S_ST1, S_ST2, S_JMP,
    S_BZ1, S_BZ2, S_BZ3, S_BZ4, S_C1, S_C2, S_C3, S_C4,
    S_D1, S_D2, S_D3, S_TRAP
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       cause_reg, cause_next;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             waiting;
  logic             timeout_hit;
  logic             func_hi_any;
  logic             func_nop;

  always_comb begin
    func_hi_any = 1'b0;
    for (int i = 7; i < FUNC_W; i++) func_hi_any = func_hi_any | func[i];
  end

  assign func_nop    = (func == (FUNC_W'(1) << 7));
  assign waiting     = (state_reg == S_IF) || (state_reg == S_LD1) || (state_reg == S_ST2);
  assign timeout_hit = (wait_cnt_reg == CNT_W'(MEM_TIMEOUT - 1));
  assign trap        = (state_reg == S_TRAP);
  assign trap_cause  = cause_reg;

  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    PCSrc      = 2'b00;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    Reg1Src    = 1'b0;
    RegDst     = 1'b0;
    writeSrc   = 2'b00;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUop      = '0;
    case (state_reg)
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_next = S_ID;
        else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_next = 2'd2;
        end
      end
      S_ID: begin
        casez (opc)
          4'b0000: state_next = S_LD1;
          4'b0001: state_next = S_ST1;
          4'b0010: state_next = S_JMP;
          4'b0100: state_next = S_BZ1;
          4'b1000: state_next = func_nop ? S_IF : S_C1;
          4'b11??: state_next = S_D1;
          default: begin
            state_next = S_TRAP;
            cause_next = 2'd1;
          end
        endcase
      end
      S_LD1: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_next = S_LD2;
        else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_next = 2'd2;
        end
      end
      S_LD2: begin
        RegWrite   = 1'b1;
        writeSrc   = 2'b10;
        state_next = S_IF;
      end
      S_ST1: state_next = S_ST2;
      S_ST2: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) state_next = S_IF;
        else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_next = 2'd2;
        end
      end
      S_JMP: begin
        PCWrite    = 1'b1;
        PCSrc      = 2'b10;
        state_next = S_IF;
      end
      S_BZ1: state_next = S_BZ2;
      S_BZ2: begin
        ALUSrcA    = 1'b1;
        ALUop      = ALUOP_W'(1);
        state_next = zero ? S_BZ3 : S_IF;
      end
      S_BZ3: begin
        ALUSrcB    = 2'b10;
        state_next = S_BZ4;
      end
      S_BZ4: begin
        PCWrite    = 1'b1;
        PCSrc      = 2'b11;
        state_next = S_IF;
      end
      S_C1: begin
        // Upper func bits (including the nop bit) must be clear for a real C-type op
        if (func_hi_any || !$onehot(func[6:0])) begin
          state_next = S_TRAP;
          cause_next = 2'd1;
        end else if (func[0]) begin
          state_next = S_C4;
        end else if (func[1]) begin
          Reg1Src    = 1'b1;
          state_next = S_C4;
        end else begin
          state_next = S_C2;
        end
      end
      S_C2: begin
        ALUSrcA = 1'b1;
        if (func[3])      ALUop = ALUOP_W'(1);
        else if (func[4]) ALUop = ALUOP_W'(2);
        else if (func[5]) ALUop = ALUOP_W'(3);
        else if (func[6]) ALUop = ALUOP_W'(4);
        state_next = S_C3;
      end
      S_C3: begin
        RegWrite   = 1'b1;
        writeSrc   = 2'b01;
        state_next = S_IF;
      end
      S_C4: begin
        RegWrite   = 1'b1;
        RegDst     = func[0];
        state_next = S_IF;
      end
      S_D1: state_next = S_D2;
      S_D2: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUop      = ALUOP_W'(opc[1:0]);
        state_next = S_D3;
      end
      S_D3: begin
        RegWrite   = 1'b1;
        writeSrc   = 2'b01;
        state_next = S_IF;
      end
      S_TRAP: state_next = S_TRAP;
      default: begin
        state_next = S_TRAP;
        cause_next = 2'd1;
      end
    endcase
    // Requests and enables drop immediately while reset is asserted
    if (rst) begin
      PCSrc    = 2'b00;
      PCWrite  = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      Reg1Src  = 1'b0;
      RegDst   = 1'b0;
      writeSrc = 2'b00;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ALUop    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IF;
      cause_reg    <= 2'd0;
      wait_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
      if (state_next != state_reg) wait_cnt_reg <= '0;
      else if (waiting && !mem_ready) wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
    end
  end

`ifdef MC_CTRL_PERF_EN
  // TRAP never returns to IF, so the count freezes there on its own
  always_ff @(posedge clk or posedge rst) begin
    if (rst) instr_retired <= '0;
    else if (state_next == S_IF && state_reg != S_IF) instr_retired <= instr_retired + PERF_W'(1);
  end
`endif

endmodule

// File: tb/tb_mc_controller_hs.sv
// Directed bench for mc_controller_hs: instruction flows, handshake, timeout, traps, async reset.
module tb_mc_controller_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  opc;
  logic [8:0]  func;
  logic        zero;
  logic        mem_ready;
  logic [1:0]  PCSrc;
  logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, Reg1Src, RegDst;
  logic [1:0]  writeSrc;
  logic        RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUop;
  logic        trap;
  logic [1:0]  trap_cause;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] instr_retired;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mc_controller_hs dut (
    .clk(clk), .rst(rst), .opc(opc), .func(func), .zero(zero), .mem_ready(mem_ready),
    .PCSrc(PCSrc), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .Reg1Src(Reg1Src), .RegDst(RegDst), .writeSrc(writeSrc),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
    .trap(trap), .trap_cause(trap_cause)
`ifdef MC_CTRL_PERF_EN
    , .instr_retired(instr_retired)
`endif
  );

  logic [17:0] ctl_obs;
  assign ctl_obs = {PCSrc, PCWrite, IorD, MemRead, MemWrite, IRWrite, Reg1Src, RegDst,
                    writeSrc, RegWrite, ALUSrcA, ALUSrcB, ALUop};

  function automatic logic [17:0] ctl(input logic [1:0] pcsrc, input logic pcw, input logic iord,
                                      input logic mr, input logic mw, input logic irw,
                                      input logic r1, input logic rd, input logic [1:0] ws,
                                      input logic rw, input logic asa, input logic [1:0] asb,
                                      input logic [2:0] aop);
    return {pcsrc, pcw, iord, mr, mw, irw, r1, rd, ws, rw, asa, asb, aop};
  endfunction

  // Expected control words per state, written directly from the state descriptions
  localparam logic [17:0] E_ZERO = '0;
  logic [17:0] e_if_w, e_if_r, e_ld1, e_ld2, e_st2, e_jmp, e_bz2, e_bz3, e_bz4;
  logic [17:0] e_c2_add, e_c3, e_c4_to, e_d2_01, e_d3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One controller cycle: drive inputs, check the decoded controls, advance past the edge
  task automatic step(input string tag, input logic mr, input logic z, input logic [17:0] exp);
    mem_ready = mr;
    zero      = z;
    #1;
    chk(tag, 32'(ctl_obs), 32'(exp));
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    e_if_w   = ctl(2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b01, 3'd0);
    e_if_r   = ctl(2'b00, 1, 0, 1, 0, 1, 0, 0, 2'b00, 0, 0, 2'b01, 3'd0);
    e_ld1    = ctl(2'b00, 0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 3'd0);
    e_ld2    = ctl(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0, 2'b00, 3'd0);
    e_st2    = ctl(2'b00, 0, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 3'd0);
    e_jmp    = ctl(2'b10, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 3'd0);
    e_bz2    = ctl(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 3'd1);
    e_bz3    = ctl(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b10, 3'd0);
    e_bz4    = ctl(2'b11, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 3'd0);
    e_c2_add = ctl(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 3'd0);
    e_c3     = ctl(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0, 2'b00, 3'd0);
    e_c4_to  = ctl(2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 1, 0, 2'b00, 3'd0);
    e_d2_01  = ctl(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 2'b10, 3'd1);
    e_d3     = ctl(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0, 2'b00, 3'd0);

    rst = 1'b1; opc = 4'b0000; func = 9'h000; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("reset_ctl", 32'(ctl_obs), 32'(E_ZERO));
    chk("reset_trap", 32'({trap, trap_cause}), 32'h0);
    rst = 1'b0;

    // Add with three IF wait states
    opc = 4'b1000; func = 9'h004;
    step("add_if_w1", 0, 0, e_if_w);
    step("add_if_w2", 0, 0, e_if_w);
    step("add_if_w3", 0, 0, e_if_w);
    step("add_if_rdy", 1, 0, e_if_r);
    step("add_id", 0, 0, E_ZERO);
    step("add_c1", 0, 0, E_ZERO);
    step("add_c2", 0, 0, e_c2_add);
    step("add_c3", 0, 0, e_c3);

    // nop goes straight back to IF from ID
    func = 9'h080;
    step("nop_if", 1, 0, e_if_r);
    step("nop_id", 0, 0, E_ZERO);

    // Branch taken
    opc = 4'b0100;
    step("bzt_if", 1, 0, e_if_r);
    step("bzt_id", 0, 0, E_ZERO);
    step("bzt_bz1", 0, 0, E_ZERO);
    step("bzt_bz2", 0, 1, e_bz2);
    step("bzt_bz3", 0, 0, e_bz3);
    step("bzt_bz4", 0, 0, e_bz4);
`ifdef MC_CTRL_PERF_EN
    chk("perf_3", instr_retired, 32'd3);
`endif

    // Branch not taken: back in IF right after BZ2, no PC write
    step("bzn_if", 1, 0, e_if_r);
    step("bzn_id", 0, 0, E_ZERO);
    step("bzn_bz1", 0, 0, E_ZERO);
    step("bzn_bz2", 0, 0, e_bz2);
    step("bzn_back_if", 0, 0, e_if_w);

    // Jump
    opc = 4'b0010;
    step("jmp_if", 1, 0, e_if_r);
    step("jmp_id", 0, 0, E_ZERO);
    step("jmp_jmp", 0, 0, e_jmp);

    // MoveTo via C4
    opc = 4'b1000; func = 9'h001;
    step("mvt_if", 1, 0, e_if_r);
    step("mvt_id", 0, 0, E_ZERO);
    step("mvt_c1", 0, 0, E_ZERO);
    step("mvt_c4", 0, 0, e_c4_to);

    // D-type immediate, opc[1:0] = 01
    opc = 4'b1101;
    step("dty_if", 1, 0, e_if_r);
    step("dty_id", 0, 0, E_ZERO);
    step("dty_d1", 0, 0, E_ZERO);
    step("dty_d2", 0, 0, e_d2_01);
    step("dty_d3", 0, 0, e_d3);

    // Store with ready on the 2nd ST2 cycle
    opc = 4'b0001;
    step("st_if", 1, 0, e_if_r);
    step("st_id", 0, 0, E_ZERO);
    step("st_st1", 0, 0, E_ZERO);
    step("st_st2_a", 0, 0, e_st2);
    step("st_st2_b", 1, 0, e_st2);
    step("st_back_if", 0, 0, e_if_w);

    // Load: ready arrives on the 15th LD1 cycle and still completes
    opc = 4'b0000;
    step("ldr_if", 1, 0, e_if_r);
    step("ldr_id", 0, 0, E_ZERO);
    for (int i = 0; i < 14; i++) step("ldr_ld1_wait", 0, 0, e_ld1);
    step("ldr_ld1_rdy", 1, 0, e_ld1);
    step("ldr_ld2", 0, 0, e_ld2);
    chk("ldr_no_trap", 32'(trap), 32'd0);

    // Load timeout: 15 cycles without ready traps with cause 2
    step("ldt_if", 1, 0, e_if_r);
    step("ldt_id", 0, 0, E_ZERO);
    for (int i = 0; i < 15; i++) step("ldt_ld1_wait", 0, 0, e_ld1);
    chk("ldt_trap", 32'(trap), 32'd1);
    chk("ldt_cause", 32'(trap_cause), 32'd2);
    for (int i = 0; i < 3; i++) step("ldt_trap_ctl", 1, 0, E_ZERO);
    chk("ldt_trap_held", 32'({trap, trap_cause}), 32'h6);
    do_reset();
    chk("rst_clears_trap", 32'({trap, trap_cause}), 32'h0);

    // Illegal opcode
    opc = 4'b0011;
    step("ill_if", 1, 0, e_if_r);
    step("ill_id", 0, 0, E_ZERO);
    chk("ill_opc_trap", 32'({trap, trap_cause}), 32'h5);
    step("ill_trap_ctl", 1, 0, E_ZERO);
    do_reset();

    // Two func bits set: trap from C1
    opc = 4'b1000; func = 9'h006;
    step("ilf_if", 1, 0, e_if_r);
    step("ilf_id", 0, 0, E_ZERO);
    chk("ilf_not_yet", 32'(trap), 32'd0);
    step("ilf_c1", 0, 0, E_ZERO);
    chk("ilf_trap", 32'({trap, trap_cause}), 32'h5);
    do_reset();

    // Async reset in the middle of ST2
    opc = 4'b0001;
    step("rst_st_if", 1, 0, e_if_r);
    step("rst_st_id", 0, 0, E_ZERO);
    step("rst_st_st1", 0, 0, E_ZERO);
    mem_ready = 1'b0;
    #1;
    chk("rst_st2_pre", 32'(ctl_obs), 32'(e_st2));
    #1;
    rst = 1'b1;
    #1;
    chk("rst_memwrite_drop", 32'(MemWrite), 32'd0);
    chk("rst_ctl_zero", 32'(ctl_obs), 32'(E_ZERO));
    #1;
    rst = 1'b0;
    #1;
    chk("rst_state_if", 32'(ctl_obs), 32'(e_if_w));
`ifdef MC_CTRL_PERF_EN
    chk("perf_reset", instr_retired, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
